amo_ctrl: RTL and testbench
===========================

AMO_CTRL -- requirements
Module: amo_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 amo_valid  input  1  execute-stage instruction is an AMO (ctrl_unit amo_wr_en qualified by pipeline valid).
REQ-004 amoop  input  amoop_t  AMO micro-op from amo_pkg: LR, SC, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU.
REQ-005 addr  input  32  effective address (rs1).
REQ-006 rs2_data  input  32  AMO source operand.
REQ-007 flush_rsv  input  1  trap/xRET; clears reservation.
REQ-008 stall  output  1  freezes pipeline upstream of execute.
REQ-009 dm_req / dm_we  output  1/1  data-memory request, write enable.
REQ-010 dm_addr / dm_wdata  output  32/32  word address ({addr[31:2],2'b00}), write data.
REQ-011 dm_rdata / dm_ack  input  32/1  read data valid with ack; ack completes current request.
REQ-012 rd_data / rd_valid  output  32/1  writeback value, one-cycle valid pulse.
REQ-013 misalign  output  1  one-cycle pulse: addr[1:0] != 0.

Function
REQ-014 FSM states IDLE, READ, WRITE, DONE, held in amo_state_t.
REQ-015 IDLE, amo_valid=1, addr[1:0]!=0: no memory access -> DONE, misalign=1 in DONE, rd_valid=0.
REQ-016 IDLE, amo_valid=1, aligned: SC with rsv_valid and rsv_addr==addr[31:2] -> WRITE; SC otherwise -> DONE with rd_data=1; all other ops -> READ.
REQ-017 READ: dm_req=1, dm_we=0; on dm_ack capture dm_rdata into old_q; LR -> set reservation, DONE; others -> compute new_q, WRITE.
REQ-018 WRITE: dm_req=1, dm_we=1, dm_wdata = rs2_data for SC, new_q otherwise; on dm_ack -> DONE.
REQ-019 DONE: stall=0; rd_valid=1 unless misaligned; rd_data = old_q (LR/RMW), 0 (SC success), 1 (SC fail); -> IDLE next cycle.
REQ-020 stall = (IDLE and amo_valid) or READ or WRITE; combinational.
REQ-021 dm_req, dm_we, dm_addr, dm_wdata held stable until dm_ack; dm_ack ignored when dm_req=0; ack in first request cycle allowed (one-cycle phase).
REQ-022 Compute: ADD modulo 2^32; MIN/MAX signed 32-bit; MINU/MAXU unsigned; SWAP new = rs2_data.
REQ-023 Any SC (success or fail) clears reservation when leaving its decision state.
REQ-024 flush_rsv clears reservation in any state; flush_rsv coincident with LR ack: flush wins, reservation stays clear.
REQ-025 Only one AMO outstanding; amo_valid outside IDLE ignored.
REQ-026 Minimum latency: RMW 3 cycles stalled with zero-wait memory (IDLE, READ, WRITE) then DONE.

Reset
REQ-027 rst: state=IDLE, rsv_valid=0, rsv_addr=0, old_q=0, new_q=0; all outputs 0 (stall follows amo_valid per REQ-020 after release).
REQ-028 rst asserted mid-READ/WRITE aborts immediately: dm_req drops same cycle, no rd_valid issued.

Structure
REQ-029 amo_state_t and reservation-granule constant (word, 4 bytes) in amo_pkg, beside amoop_t.
REQ-030 Combinational compute in sub-module amo_alu (amoop, old, rs2 -> new); FSM and reservation in amo_ctrl.

Verification
REQ-031 AMOADD addr 0x100, mem 0x0000_0005, rs2 0x3, zero-wait -> write 0x8 to 0x100, rd_data 0x5, stall high 3 cycles.
REQ-032 LR 0x200 then SC 0x200 rs2 0xAB -> write 0xAB, rd_data 0; second SC 0x200 -> no write, rd_data 1.
REQ-033 LR 0x200, flush_rsv pulse, SC 0x200 -> no dm_req, rd_data 1.
REQ-034 AMOMIN mem 0xFFFF_FFFE, rs2 0x1 -> write 0xFFFF_FFFE; AMOMINU same -> write 0x1.
REQ-035 AMOSWAP addr 0x102 -> misalign pulse, no dm_req, rd_valid 0.
REQ-036 AMOOR with 4-cycle dm_ack delay, rst asserted in WRITE -> dm_req 0 same cycle, state IDLE, no rd_valid.

Source files
------------

// File: rtl/amo_pkg.sv
// rtl/amo_pkg.sv - AMO micro-op, FSM state and reservation granule definitions
package amo_pkg;

    typedef enum logic [3:0] {
        AMO_LR   = 4'd0,
        AMO_SC   = 4'd1,
        AMO_SWAP = 4'd2,
        AMO_ADD  = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_MIN  = 4'd7,
        AMO_MAX  = 4'd8,
        AMO_MINU = 4'd9,
        AMO_MAXU = 4'd10
    } amoop_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } amo_state_t;

    // Reservation granule is one word; addresses compare above this bit.
    localparam int RSV_GRANULE_BYTES = 4;
    localparam int RSV_LSB           = $clog2(RSV_GRANULE_BYTES);

endpackage

// File: rtl/amo_alu.sv
// rtl/amo_alu.sv - combinational read-modify-write value for AMO ops
module amo_alu
    import amo_pkg::*;
(
    input  amoop_t      amoop,
    input  logic [31:0] old_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] new_data
);

    always_comb begin
        new_data = rs2_data;
        case (amoop)
            AMO_ADD:  new_data = old_data + rs2_data;
            AMO_XOR:  new_data = old_data ^ rs2_data;
            AMO_AND:  new_data = old_data & rs2_data;
            AMO_OR:   new_data = old_data | rs2_data;
            AMO_MIN:  new_data = ($signed(old_data) < $signed(rs2_data)) ? old_data : rs2_data;
            AMO_MAX:  new_data = ($signed(old_data) > $signed(rs2_data)) ? old_data : rs2_data;
            AMO_MINU: new_data = (old_data < rs2_data) ? old_data : rs2_data;
            AMO_MAXU: new_data = (old_data > rs2_data) ? old_data : rs2_data;
            default:  new_data = rs2_data;
        endcase
    end

endmodule

// File: rtl/amo_ctrl.sv
// rtl/amo_ctrl.sv - AMO / LR / SC sequencer with single-word reservation
module amo_ctrl
    import amo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        amo_valid,
    input  amoop_t      amoop,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    input  logic        flush_rsv,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        misalign
);

    amo_state_t           state_q, state_d;
    amoop_t               op_q, op_d;
    logic [31:RSV_LSB]    addr_q, addr_d;
    logic [31:0]          rs2_q, rs2_d;
    logic [31:0]          old_q, old_d;
    logic [31:0]          new_q, new_d;
    logic                 rsv_valid_q, rsv_valid_d;
    logic [31:RSV_LSB]    rsv_addr_q, rsv_addr_d;
    logic                 dm_req_q, dm_req_d;
    logic                 dm_we_q, dm_we_d;
    logic [31:0]          dm_wdata_q, dm_wdata_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 misalign_q, misalign_d;
    logic [31:0]          alu_new;

    amo_alu u_alu (
        .amoop    (op_q),
        .old_data (dm_rdata),
        .rs2_data (rs2_q),
        .new_data (alu_new)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        rs2_d       = rs2_q;
        old_d       = old_q;
        new_d       = new_q;
        rsv_valid_d = rsv_valid_q;
        rsv_addr_d  = rsv_addr_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_wdata_d  = dm_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        misalign_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (amo_valid) begin
                    op_d   = amoop;
                    addr_d = addr[31:RSV_LSB];
                    rs2_d  = rs2_data;
                    // Any SC consumes the reservation regardless of its outcome.
                    if (amoop == AMO_SC) begin
                        rsv_valid_d = 1'b0;
                    end
                    if (addr[RSV_LSB-1:0] != '0) begin
                        state_d    = ST_DONE;
                        misalign_d = 1'b1;
                    end else if (amoop == AMO_SC) begin
                        if (rsv_valid_q && (rsv_addr_q == addr[31:RSV_LSB])) begin
                            state_d    = ST_WRITE;
                            dm_req_d   = 1'b1;
                            dm_we_d    = 1'b1;
                            dm_wdata_d = rs2_data;
                        end else begin
                            state_d    = ST_DONE;
                            rd_valid_d = 1'b1;
                            rd_data_d  = 32'd1;
                        end
                    end else begin
                        state_d  = ST_READ;
                        dm_req_d = 1'b1;
                        dm_we_d  = 1'b0;
                    end
                end
            end
            ST_READ: begin
                if (dm_ack) begin
                    old_d = dm_rdata;
                    if (op_q == AMO_LR) begin
                        rsv_valid_d = 1'b1;
                        rsv_addr_d  = addr_q;
                        state_d     = ST_DONE;
                        dm_req_d    = 1'b0;
                        rd_valid_d  = 1'b1;
                        rd_data_d   = dm_rdata;
                    end else begin
                        new_d      = alu_new;
                        dm_wdata_d = alu_new;
                        dm_we_d    = 1'b1;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (dm_ack) begin
                    dm_req_d   = 1'b0;
                    dm_we_d    = 1'b0;
                    state_d    = ST_DONE;
                    rd_valid_d = 1'b1;
                    rd_data_d  = (op_q == AMO_SC) ? 32'd0 : old_q;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                rd_data_d = 32'd0;
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush beats a coincident LR reservation set.
        if (flush_rsv) begin
            rsv_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= AMO_LR;
            addr_q      <= '0;
            rs2_q       <= '0;
            old_q       <= '0;
            new_q       <= '0;
            rsv_valid_q <= 1'b0;
            rsv_addr_q  <= '0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_wdata_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            rs2_q       <= rs2_d;
            old_q       <= old_d;
            new_q       <= new_d;
            rsv_valid_q <= rsv_valid_d;
            rsv_addr_q  <= rsv_addr_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_wdata_q  <= dm_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            misalign_q  <= misalign_d;
        end
    end

    assign stall    = ((state_q == ST_IDLE) && amo_valid) || (state_q == ST_READ) || (state_q == ST_WRITE);
    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = {addr_q, {RSV_LSB{1'b0}}};
    assign dm_wdata = dm_wdata_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_amo_ctrl.sv
// tb/tb_amo_ctrl.sv - directed table-driven bench for amo_ctrl
module tb_amo_ctrl;
    import amo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        amo_valid;
    amoop_t      amoop;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic        flush_rsv;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        misalign;

    amo_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .amo_valid (amo_valid),
        .amoop     (amoop),
        .addr      (addr),
        .rs2_data  (rs2_data),
        .flush_rsv (flush_rsv),
        .stall     (stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        amoop_t      op;
        logic [31:0] a;
        logic [31:0] rs2;
        logic [31:0] mem;
        int          dly;
        int          exp_acc;
        bit          exp_wr;
        logic [31:0] exp_wdata;
        bit          exp_rdv;
        logic [31:0] exp_rd;
        bit          exp_mis;
        int          exp_stall;
    } vec_t;

    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          dly_cnt;
    int          n_acc;
    int          n_wr;
    int          stall_cnt;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [31:0] r_addr;
    logic [31:0] rd_seen;
    bit          rdv_seen;
    bit          mis_seen;
    bit          done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder, called at a falling edge to set dm_ack for the next rising edge.
    task automatic mem_step(input logic [31:0] mem, input int dly);
        dm_ack = 1'b0;
        if (dm_req) begin
            if (dly_cnt >= dly) begin
                dm_ack  = 1'b1;
                dly_cnt = 0;
                n_acc++;
                if (dm_we) begin
                    n_wr++;
                    w_addr = dm_addr;
                    w_data = dm_wdata;
                end else begin
                    dm_rdata = mem;
                    r_addr   = dm_addr;
                end
            end else begin
                dly_cnt++;
            end
        end
    endtask

    task automatic run_amo(input amoop_t op, input logic [31:0] a, input logic [31:0] r,
                           input logic [31:0] mem, input int dly);
        n_acc = 0; n_wr = 0; stall_cnt = 0; dly_cnt = 0;
        w_addr = '0; w_data = '0; r_addr = '0; rd_seen = '0;
        rdv_seen = 1'b0; mis_seen = 1'b0; done = 1'b0;
        @(negedge clk);
        amo_valid = 1'b1; amoop = op; addr = a; rs2_data = r;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (stall) stall_cnt++;
            if (rd_valid || misalign) begin
                done      = 1'b1;
                rdv_seen  = rd_valid;
                mis_seen  = misalign;
                rd_seen   = rd_data;
                amo_valid = 1'b0;
                dm_ack    = 1'b0;
            end else begin
                mem_step(mem, dly);
                @(negedge clk);
            end
        end
        check("op_completes", {31'd0, done}, 32'd1);
        @(negedge clk);
        #1;
        check("done_pulse_one_cycle", {30'd0, rd_valid, misalign}, 32'd0);
    endtask

    logic [31:0] exp_word;
    int          we_cycles;
    bit          hit;
    bit          bad;

    initial begin
        vecs.push_back('{AMO_ADD,  32'h100, 32'h3,    32'h5,        0, 2, 1, 32'h8,        1, 32'h5,        0, 3});
        vecs.push_back('{AMO_ADD,  32'h104, 32'h2,    32'hFFFF_FFFF, 2, 2, 1, 32'h1,        1, 32'hFFFF_FFFF, 0, 7});
        vecs.push_back('{AMO_LR,   32'h200, 32'h0,    32'h1234,     0, 1, 0, 32'h0,        1, 32'h1234,     0, 2});
        vecs.push_back('{AMO_SC,   32'h200, 32'hAB,   32'h0,        0, 1, 1, 32'hAB,       1, 32'h0,        0, 2});
        vecs.push_back('{AMO_SC,   32'h200, 32'hCD,   32'h0,        0, 0, 0, 32'h0,        1, 32'h1,        0, 1});
        vecs.push_back('{AMO_MIN,  32'h300, 32'h1,    32'hFFFF_FFFE, 0, 2, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFE, 0, 3});
        vecs.push_back('{AMO_MINU, 32'h300, 32'h1,    32'hFFFF_FFFE, 0, 2, 1, 32'h1,        1, 32'hFFFF_FFFE, 0, 3});
        vecs.push_back('{AMO_MAX,  32'h300, 32'h1,    32'hFFFF_FFFE, 0, 2, 1, 32'h1,        1, 32'hFFFF_FFFE, 0, 3});
        vecs.push_back('{AMO_MAXU, 32'h300, 32'h1,    32'hFFFF_FFFE, 0, 2, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFE, 0, 3});
        vecs.push_back('{AMO_XOR,  32'h10,  32'h0FF0, 32'hF0F0,     0, 2, 1, 32'hFF00,     1, 32'hF0F0,     0, 3});
        vecs.push_back('{AMO_AND,  32'h10,  32'h0FF0, 32'hF0F0,     1, 2, 1, 32'h00F0,     1, 32'hF0F0,     0, 5});
        vecs.push_back('{AMO_OR,   32'h10,  32'h0FF0, 32'hF0F0,     0, 2, 1, 32'hFFF0,     1, 32'hF0F0,     0, 3});
        vecs.push_back('{AMO_SWAP, 32'h14,  32'h55,   32'h7,        0, 2, 1, 32'h55,       1, 32'h7,        0, 3});
        vecs.push_back('{AMO_SWAP, 32'h102, 32'h55,   32'h7,        0, 0, 0, 32'h0,        0, 32'h0,        1, 1});
        vecs.push_back('{AMO_LR,   32'h208, 32'h0,    32'h9,        1, 1, 0, 32'h0,        1, 32'h9,        0, 3});
        vecs.push_back('{AMO_SC,   32'h20C, 32'h11,   32'h0,        0, 0, 0, 32'h0,        1, 32'h1,        0, 1});
        vecs.push_back('{AMO_SC,   32'h208, 32'h22,   32'h0,        0, 0, 0, 32'h0,        1, 32'h1,        0, 1});

        rst = 1'b1; amo_valid = 1'b0; amoop = AMO_LR; addr = '0; rs2_data = '0;
        flush_rsv = 1'b0; dm_rdata = '0; dm_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall",    {31'd0, stall},    32'd0);
        check("reset_dm_req",   {31'd0, dm_req},   32'd0);
        check("reset_dm_we",    {31'd0, dm_we},    32'd0);
        check("reset_dm_addr",  dm_addr,           32'd0);
        check("reset_dm_wdata", dm_wdata,          32'd0);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_rd_data",  rd_data,           32'd0);
        check("reset_misalign", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stray ack with no request outstanding must be ignored.
        @(negedge clk);
        dm_ack = 1'b1;
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        check("stray_ack_req",   {31'd0, dm_req},   32'd0);
        check("stray_ack_rdv",   {31'd0, rd_valid}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_amo(vecs[i].op, vecs[i].a, vecs[i].rs2, vecs[i].mem, vecs[i].dly);
            exp_word = {vecs[i].a[31:2], 2'b00};
            check($sformatf("v%0d_accesses", i), n_acc,              vecs[i].exp_acc);
            check($sformatf("v%0d_writes", i),   n_wr,               {31'd0, vecs[i].exp_wr});
            check($sformatf("v%0d_stall", i),    stall_cnt,          vecs[i].exp_stall);
            check($sformatf("v%0d_rd_valid", i), {31'd0, rdv_seen}, {31'd0, vecs[i].exp_rdv});
            check($sformatf("v%0d_misalign", i), {31'd0, mis_seen}, {31'd0, vecs[i].exp_mis});
            if (vecs[i].exp_rdv) check($sformatf("v%0d_rd_data", i), rd_seen, vecs[i].exp_rd);
            if (vecs[i].exp_wr) begin
                check($sformatf("v%0d_wdata", i), w_data, vecs[i].exp_wdata);
                check($sformatf("v%0d_waddr", i), w_addr, exp_word);
            end
            if (vecs[i].exp_acc > vecs[i].exp_wr) check($sformatf("v%0d_raddr", i), r_addr, exp_word);
        end

        // LR, flush pulse, SC: reservation gone, no memory access.
        run_amo(AMO_LR, 32'h200, 32'h0, 32'h77, 0);
        @(negedge clk);
        flush_rsv = 1'b1;
        @(negedge clk);
        flush_rsv = 1'b0;
        run_amo(AMO_SC, 32'h200, 32'hAB, 32'h0, 0);
        check("flush_sc_acc",     n_acc,   32'd0);
        check("flush_sc_rd_data", rd_seen, 32'd1);

        // Flush held across the LR ack beats the reservation set.
        flush_rsv = 1'b1;
        run_amo(AMO_LR, 32'h200, 32'h0, 32'h66, 0);
        flush_rsv = 1'b0;
        check("flush_lr_rd_data", rd_seen, 32'h66);
        run_amo(AMO_SC, 32'h200, 32'hAB, 32'h0, 0);
        check("flush_ack_sc_acc",     n_acc,   32'd0);
        check("flush_ack_sc_rd_data", rd_seen, 32'd1);

        // AMOOR with a slow memory, reset while the write is pending.
        n_acc = 0; n_wr = 0; dly_cnt = 0; we_cycles = 0; hit = 1'b0;
        @(negedge clk);
        amo_valid = 1'b1; amoop = AMO_OR; addr = 32'h400; rs2_data = 32'h0F;
        for (int c = 0; c < 40 && !hit; c++) begin
            #1;
            if (dm_req && dm_we) we_cycles++;
            if (we_cycles == 2) hit = 1'b1;
            else begin
                mem_step(32'h30, 4);
                @(negedge clk);
            end
        end
        check("rst_reached_write", {31'd0, hit}, 32'd1);
        check("rst_write_data",    dm_wdata,     32'h3F);
        rst = 1'b1; amo_valid = 1'b0; dm_ack = 1'b0;
        #1;
        check("rst_dm_req_drop", {31'd0, dm_req}, 32'd0);
        check("rst_dm_we_drop",  {31'd0, dm_we},  32'd0);
        check("rst_stall_drop",  {31'd0, stall},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (rd_valid || dm_req) bad = 1'b1;
        end
        check("rst_no_rd_valid", {31'd0, bad}, 32'd0);

        // Back to normal operation after the abort.
        run_amo(AMO_ADD, 32'h100, 32'h3, 32'h5, 0);
        check("post_rst_wdata",   w_data,    32'h8);
        check("post_rst_rd_data", rd_seen,   32'h5);
        check("post_rst_stall",   stall_cnt, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
